// File: rtl/decode_stage_if.sv
// Fetch/execute-facing bundle of decode_stage: fetched word in, fetch control
// and decoded ID fields out.
interface decode_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] if_pc;
  logic              stall;
  logic              pc_en;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_addr;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [3:0]        id_opcode;
  logic [3:0]        id_rd;
  logic [3:0]        id_rs1;
  logic [3:0]        id_rs2;
  logic [7:0]        id_imm;
  logic              id_illegal;
  logic              halted;

  modport slave (
    input  instr, if_pc, stall,
    output pc_en, branch_en, branch_addr, id_valid, id_pc, id_opcode,
           id_rd, id_rs1, id_rs2, id_imm, id_illegal, halted
  );

  modport master (
    output instr, if_pc, stall,
    input  pc_en, branch_en, branch_addr, id_valid, id_pc, id_opcode,
           id_rd, id_rs1, id_rs2, id_imm, id_illegal, halted
  );
endinterface

// File: rtl/decode_stage.sv
// IF/ID register and decoder: captures the fetched word, redirects fetch on
// unconditional jumps (one bubble) and stops fetch for good on HALT.
module decode_stage #(
  parameter int         DATA_W      = 16,
  parameter int         ADDR_W      = 8,
  parameter logic [3:0] JMP_OPCODE  = 4'h9,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BRANCH = 2'd1,
    HALT   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic              valid_q, valid_d;
  logic              illegal_q, illegal_d;
  logic              halted_q, halted_d;
  logic              br_en_q, br_en_d;
  logic [ADDR_W-1:0] br_addr_q, br_addr_d;
  logic [3:0]        op_s;

  function automatic logic is_illegal(input logic [3:0] op);
    return !((op <= 4'd8) || (op == JMP_OPCODE) || (op == HALT_OPCODE));
  endfunction

  assign op_s = bus.instr[DATA_W-1 -: 4];

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    id_pc_d   = id_pc_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    halted_d  = halted_q;
    br_en_d   = br_en_q;
    br_addr_d = br_addr_q;
    case (state_q)
      RUN: begin
        if (!bus.stall) begin
          instr_d   = bus.instr;
          id_pc_d   = bus.if_pc;
          valid_d   = 1'b1;
          illegal_d = is_illegal(op_s);
          if (op_s == JMP_OPCODE) begin
            state_d   = BRANCH;
            br_en_d   = 1'b1;
            br_addr_d = {bus.instr[ADDR_W-1:1], 1'b0};
          end else if (op_s == HALT_OPCODE) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      BRANCH: begin
        // The redirect always issues; a stalled JMP stays visible in ID.
        state_d = RUN;
        br_en_d = 1'b0;
        if (bus.stall) begin
          valid_d = valid_q;
        end else begin
          valid_d = 1'b0;
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      instr_q   <= {DATA_W{1'b0}};
      id_pc_q   <= {ADDR_W{1'b0}};
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
      br_en_q   <= 1'b0;
      br_addr_q <= {ADDR_W{1'b0}};
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      id_pc_q   <= id_pc_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
      br_en_q   <= br_en_d;
      br_addr_q <= br_addr_d;
    end
  end

  assign bus.pc_en       = !rst && (state_q == RUN) && !bus.stall;
  assign bus.branch_en   = br_en_q;
  assign bus.branch_addr = br_addr_q;
  assign bus.id_valid    = valid_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_opcode   = instr_q[DATA_W-1 -: 4];
  assign bus.id_rd       = instr_q[DATA_W-5 -: 4];
  assign bus.id_rs1      = instr_q[7:4];
  assign bus.id_rs2      = instr_q[3:0];
  assign bus.id_imm      = instr_q[7:0];
  assign bus.id_illegal  = illegal_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a small fetch-unit model driving instr/if_pc.
module tb_decode_stage;
  logic       clk;
  logic       rst;
  logic [7:0] fpc;
  logic [15:0] mem [0:255];
  int checks;
  int errors;

  decode_stage_if #(.DATA_W(16), .ADDR_W(8)) dif ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dif.instr = mem[fpc];
  assign dif.if_pc = fpc;

  always @(posedge clk or posedge rst) begin
    if (rst)                fpc <= 8'h00;
    else if (dif.branch_en) fpc <= dif.branch_addr;
    else if (dif.pc_en)     fpc <= fpc + 8'd2;
  end

  typedef struct {
    logic        stall;
    logic        valid;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        ill;
    logic        halt;
    logic        pcen;
    logic        bren;
    logic [7:0]  baddr;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    dif.stall = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    mem[8'h00] = 16'h1123;
    mem[8'h02] = 16'h2456;
    mem[8'h04] = 16'h3789;
    mem[8'h06] = 16'h9011;
    mem[8'h08] = 16'h4AAA;
    mem[8'h10] = 16'h5321;
    mem[8'h12] = 16'hB000;
    mem[8'h14] = 16'h6111;
    mem[8'h16] = 16'hF000;

    //         stall valid pc     instr     ill   halt  pcen  bren  baddr
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 8'h00, 16'h1123, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 8'h02, 16'h2456, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 8'h02, 16'h2456, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 8'h02, 16'h2456, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 8'h02, 16'h2456, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 1'b1, 8'h04, 16'h3789, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 1'b1, 8'h06, 16'h9011, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10};
    tbl[8]  = '{1'b0, 1'b0, 8'h06, 16'h9011, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10};
    tbl[9]  = '{1'b0, 1'b1, 8'h10, 16'h5321, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10};
    tbl[10] = '{1'b0, 1'b1, 8'h12, 16'hB000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10};
    tbl[11] = '{1'b0, 1'b1, 8'h14, 16'h6111, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10};
    tbl[12] = '{1'b0, 1'b1, 8'h16, 16'hF000, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10};
    tbl[13] = '{1'b0, 1'b0, 8'h16, 16'hF000, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc_en",    {31'd0, dif.pc_en},     32'd0);
    chk("rst_valid",    {31'd0, dif.id_valid},  32'd0);
    chk("rst_id_pc",    {24'd0, dif.id_pc},     32'd0);
    chk("rst_fields",   {16'd0, dif.id_opcode, dif.id_rd, dif.id_rs1, dif.id_rs2}, 32'd0);
    chk("rst_halted",   {31'd0, dif.halted},    32'd0);
    chk("rst_br_en",    {31'd0, dif.branch_en}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      v = tbl[i];
      dif.stall = v.stall;
      #1;
      chk($sformatf("r%0d_valid", i), {31'd0, dif.id_valid}, {31'd0, v.valid});
      chk($sformatf("r%0d_pc", i), {24'd0, dif.id_pc}, {24'd0, v.pc});
      chk($sformatf("r%0d_fields", i),
          {16'd0, dif.id_opcode, dif.id_rd, dif.id_rs1, dif.id_rs2}, {16'd0, v.instr});
      chk($sformatf("r%0d_imm", i), {24'd0, dif.id_imm}, {24'd0, v.instr[7:0]});
      chk($sformatf("r%0d_ill", i), {31'd0, dif.id_illegal}, {31'd0, v.ill});
      chk($sformatf("r%0d_halt", i), {31'd0, dif.halted}, {31'd0, v.halt});
      chk($sformatf("r%0d_pc_en", i), {31'd0, dif.pc_en}, {31'd0, v.pcen});
      chk($sformatf("r%0d_br_en", i), {31'd0, dif.branch_en}, {31'd0, v.bren});
      chk($sformatf("r%0d_br_addr", i), {24'd0, dif.branch_addr}, {24'd0, v.baddr});
    end

    // Halt persists: fetch stays frozen past the HALT word.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("halt%0d_pc_en", k), {31'd0, dif.pc_en}, 32'd0);
      chk($sformatf("halt%0d_halted", k), {31'd0, dif.halted}, 32'd1);
      chk($sformatf("halt%0d_fpc", k), {24'd0, fpc}, 32'h18);
    end

    // Reset exits HALT and fetch resumes from pc 0.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("hrst_halted", {31'd0, dif.halted},   32'd0);
    chk("hrst_valid",  {31'd0, dif.id_valid}, 32'd0);
    chk("hrst_pc_en",  {31'd0, dif.pc_en},    32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("hrel_pc_en",  {31'd0, dif.pc_en},    32'd1);
    @(negedge clk);
    #1;
    chk("hrel_valid",  {31'd0, dif.id_valid}, 32'd1);
    chk("hrel_id_pc",  {24'd0, dif.id_pc},    32'd0);
    chk("hrel_op",     {28'd0, dif.id_opcode}, 32'd1);

    // JMP captured, stall rises during BRANCH.
    @(negedge clk);
    rst = 1'b1;
    mem[8'h00] = 16'h9020;
    mem[8'h20] = 16'h7ABC;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dif.stall = 1'b1;
    #1;
    chk("js_br_en",    {31'd0, dif.branch_en}, 32'd1);
    chk("js_pc_en",    {31'd0, dif.pc_en},     32'd0);
    chk("js_br_addr",  {24'd0, dif.branch_addr}, 32'h20);
    chk("js_op",       {28'd0, dif.id_opcode}, 32'd9);
    @(negedge clk);
    #1;
    chk("js2_br_en",   {31'd0, dif.branch_en}, 32'd0);
    chk("js2_pc_en",   {31'd0, dif.pc_en},     32'd0);
    chk("js2_valid",   {31'd0, dif.id_valid},  32'd1);
    chk("js2_op",      {28'd0, dif.id_opcode}, 32'd9);
    chk("js2_fpc",     {24'd0, fpc},           32'h20);
    @(negedge clk);
    dif.stall = 1'b0;
    #1;
    chk("js3_pc_en",   {31'd0, dif.pc_en},     32'd1);
    chk("js3_id_pc",   {24'd0, dif.id_pc},     32'd0);
    @(negedge clk);
    #1;
    chk("js4_id_pc",   {24'd0, dif.id_pc},     32'h20);
    chk("js4_op",      {28'd0, dif.id_opcode}, 32'd7);
    chk("js4_valid",   {31'd0, dif.id_valid},  32'd1);

    // Async reset pulsed while branch_en is high.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("ar_br_en_pre", {31'd0, dif.branch_en}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_br_en",    {31'd0, dif.branch_en}, 32'd0);
    chk("ar_pc_en",    {31'd0, dif.pc_en},     32'd0);
    chk("ar_valid",    {31'd0, dif.id_valid},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_rel_pc_en", {31'd0, dif.pc_en},     32'd1);
    chk("ar_rel_br_en", {31'd0, dif.branch_en}, 32'd0);
    @(negedge clk);
    #1;
    chk("ar_rel_valid", {31'd0, dif.id_valid},  32'd1);
    chk("ar_rel_id_pc", {24'd0, dif.id_pc},     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
